// File: rtl/pitch_scorer.sv
// Grades one sung/reference frequency pair per start pulse into a 0/1/4/7/10 score and keeps song totals.
// Define OCTAVE_FOLD_EN to fold the pair into a common octave before grading; otherwise octave errors score 0.
module pitch_scorer #(
  parameter int FREQ_W    = 15,
  parameter int MAX_OCT   = 8,
  parameter int TOL_SHIFT = 6,
  parameter int ACC_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              start,
  input  logic              clear_acc,
  input  logic [FREQ_W-1:0] sung_freq_in,
  input  logic [FREQ_W-1:0] ref_freq_in,
  output logic              busy,
  output logic              done,
  output logic [3:0]        score,
  output logic              out_of_range,
  output logic [ACC_W-1:0]  total_score,
  output logic [ACC_W-1:0]  note_count
);

  localparam int SW = FREQ_W + MAX_OCT + 1;
  localparam int DW = SW + TOL_SHIFT;

  typedef enum logic [2:0] {IDLE, FOLD, DIFF, SCORE, DONE} state_t;

  state_t            r_state, w_next;
  logic [SW-1:0]     r_s, r_r, r_d, r_base;
  logic              r_invalid, r_done, r_oor;
  logic [3:0]        r_score;
  logic [ACC_W-1:0]  r_total, r_count;

  logic              w_sample, w_set_invalid;
  logic [SW-1:0]     w_d, w_base;
  logic [DW-1:0]     w_dx, w_bx;
  logic [3:0]        w_score;
  logic [ACC_W:0]    w_tot_sum;
  logic [ACC_W-1:0]  w_tot_sat, w_cnt_sat;

`ifdef OCTAVE_FOLD_EN
  localparam int KW = $clog2(MAX_OCT + 1);
  localparam logic [KW-1:0] K_MAX = KW'(MAX_OCT);

  logic [KW-1:0]     r_k;
  logic              w_shift_r, w_shift_s;
  logic [SW-1:0]     w_r2, w_s2, w_d1, w_d2;

  // Doubling cannot overflow: s/r never exceed FREQ_W+MAX_OCT significant bits.
  assign w_r2 = r_r << 1;
  assign w_s2 = r_s << 1;
`endif

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    w_next        = r_state;
    w_sample      = 1'b0;
    w_set_invalid = 1'b0;
`ifdef OCTAVE_FOLD_EN
    w_shift_r     = 1'b0;
    w_shift_s     = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        if (start) begin
          w_sample = 1'b1;
          w_next   = FOLD;
        end
      end
      FOLD: begin
        if (r_s == '0 || r_r == '0) begin
          w_set_invalid = 1'b1;
          w_next        = DIFF;
        end
`ifdef OCTAVE_FOLD_EN
        else if (r_s >= w_r2) begin
          if (r_k == K_MAX) begin
            w_set_invalid = 1'b1;
            w_next        = DIFF;
          end else begin
            w_shift_r = 1'b1;
          end
        end else if (r_r >= w_s2) begin
          if (r_k == K_MAX) begin
            w_set_invalid = 1'b1;
            w_next        = DIFF;
          end else begin
            w_shift_s = 1'b1;
          end
        end
`endif
        else begin
          w_next = DIFF;
        end
      end
      DIFF:    w_next = SCORE;
      SCORE:   w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Error against the nearer of the two neighbouring octave images when folding.
  always_comb begin
`ifdef OCTAVE_FOLD_EN
    if (r_s >= r_r) begin
      w_d1   = r_s - r_r;
      w_d2   = w_r2 - r_s;
      w_base = r_r;
    end else begin
      w_d1   = r_r - r_s;
      w_d2   = w_s2 - r_r;
      w_base = r_s;
    end
    w_d = (w_d1 < w_d2) ? w_d1 : w_d2;
`else
    w_d    = (r_s >= r_r) ? (r_s - r_r) : (r_r - r_s);
    w_base = r_r;
`endif
  end

  assign w_dx = DW'(r_d);
  assign w_bx = DW'(r_base);

  always_comb begin
    w_score = 4'd0;
    if (r_invalid)                               w_score = 4'd0;
    else if ((w_dx << TOL_SHIFT)       <= w_bx)  w_score = 4'd10;
    else if ((w_dx << (TOL_SHIFT - 1)) <= w_bx)  w_score = 4'd7;
    else if ((w_dx << (TOL_SHIFT - 2)) <= w_bx)  w_score = 4'd4;
    else if ((w_dx << (TOL_SHIFT - 3)) <= w_bx)  w_score = 4'd1;
  end

  assign w_tot_sum = {1'b0, r_total} + {{(ACC_W - 3){1'b0}}, r_score};
  assign w_tot_sat = w_tot_sum[ACC_W] ? '1 : w_tot_sum[ACC_W-1:0];
  assign w_cnt_sat = (&r_count) ? r_count : r_count + ACC_W'(1);

  // NOTE: sequential state uses non-blocking assignments only; the reset is asynchronous.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_s       <= '0;
      r_r       <= '0;
      r_d       <= '0;
      r_base    <= '0;
      r_invalid <= 1'b0;
      r_done    <= 1'b0;
      r_oor     <= 1'b0;
      r_score   <= '0;
      r_total   <= '0;
      r_count   <= '0;
`ifdef OCTAVE_FOLD_EN
      r_k       <= '0;
`endif
    end else if (enable) begin
      r_state <= w_next;
      r_done  <= (r_state == DONE);

      if (w_sample) begin
        r_s       <= SW'(sung_freq_in);
        r_r       <= SW'(ref_freq_in);
        r_invalid <= 1'b0;
`ifdef OCTAVE_FOLD_EN
        r_k       <= '0;
`endif
      end
      if (w_set_invalid) r_invalid <= 1'b1;
`ifdef OCTAVE_FOLD_EN
      if (w_shift_r) begin
        r_r <= w_r2;
        r_k <= r_k + KW'(1);
      end
      if (w_shift_s) begin
        r_s <= w_s2;
        r_k <= r_k + KW'(1);
      end
`endif

      if (r_state == DIFF) begin
        r_d    <= w_d;
        r_base <= w_base;
      end
      if (r_state == SCORE) begin
        r_score <= w_score;
        r_oor   <= r_invalid;
      end

      // A clear arriving with a finished note restarts the totals from that note.
      if (clear_acc && r_state == DONE) begin
        r_total <= ACC_W'(r_score);
        r_count <= ACC_W'(1);
      end else if (clear_acc) begin
        r_total <= '0;
        r_count <= '0;
      end else if (r_state == DONE) begin
        r_total <= w_tot_sat;
        r_count <= w_cnt_sat;
      end
    end
  end

  // The done flag holds while stalled and is masked, so it reappears once enable returns.
  assign done         = r_done & enable;
  assign busy         = (r_state != IDLE);
  assign score        = r_score;
  assign out_of_range = r_oor;
  assign total_score  = r_total;
  assign note_count   = r_count;

endmodule

// File: tb/tb_pitch_scorer.sv
// Directed bench for pitch_scorer: vector table for scoring/latency plus hand sequences for
// busy-start, clear_acc, enable stall, mid-note reset and accumulator saturation.
module tb_pitch_scorer;

  logic        clk = 1'b0;
  logic        rst, enable, start, clear_acc;
  logic [14:0] sung_freq, ref_freq;
  logic        busy, done, oor;
  logic [3:0]  score;
  logic [15:0] total, count;
  logic        busy2, done2, oor2;
  logic [3:0]  score2, total2, count2;

  int n_total = 0;
  int n_bad   = 0;
  int exp_total = 0;
  int exp_count = 0;

  always #5 clk = ~clk;

  pitch_scorer dut (
    .clk(clk), .rst(rst), .enable(enable), .start(start), .clear_acc(clear_acc),
    .sung_freq_in(sung_freq), .ref_freq_in(ref_freq),
    .busy(busy), .done(done), .score(score), .out_of_range(oor),
    .total_score(total), .note_count(count)
  );

  pitch_scorer #(.ACC_W(4)) dut_small (
    .clk(clk), .rst(rst), .enable(enable), .start(start), .clear_acc(clear_acc),
    .sung_freq_in(sung_freq), .ref_freq_in(ref_freq),
    .busy(busy2), .done(done2), .score(score2), .out_of_range(oor2),
    .total_score(total2), .note_count(count2)
  );

  typedef struct {
    int rf;
    int sf;
    int exp_score;
    int exp_oor;
    int exp_lat;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_add(input int s);
    exp_total = (exp_total + s > 65535) ? 65535 : exp_total + s;
    exp_count = (exp_count + 1 > 65535) ? 65535 : exp_count + 1;
  endtask

  task automatic run_note(input int rf, input int sf, output int lat);
    @(negedge clk);
    ref_freq  = rf[14:0];
    sung_freq = sf[14:0];
    start     = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = c;
        break;
      end
    end
  endtask

  initial begin
    int lat, first, ndone;

`ifdef OCTAVE_FOLD_EN
    vecs[0]  = '{440,   440, 10, 0,  4};
    vecs[1]  = '{440,   880, 10, 0,  5};
    vecs[2]  = '{440,   450,  7, 0,  4};
    vecs[3]  = '{440,   870,  7, 0,  4};
    vecs[4]  = '{440,   470,  1, 0,  4};
    vecs[5]  = '{440,   500,  0, 0,  4};
    vecs[6]  = '{20,  20000,  0, 1, 12};
    vecs[7]  = '{0,     440,  0, 1,  4};
    vecs[8]  = '{440,   220, 10, 0,  5};
`else
    vecs[0]  = '{440,   440, 10, 0,  4};
    vecs[1]  = '{440,   880,  0, 0,  4};
    vecs[2]  = '{440,   450,  7, 0,  4};
    vecs[3]  = '{440,   870,  0, 0,  4};
    vecs[4]  = '{440,   470,  1, 0,  4};
    vecs[5]  = '{440,   500,  0, 0,  4};
    vecs[6]  = '{20,  20000,  0, 0,  4};
    vecs[7]  = '{0,     440,  0, 1,  4};
    vecs[8]  = '{440,   220,  0, 0,  4};
`endif
    vecs[9]  = '{640,   650, 10, 0,  4};
    vecs[10] = '{640,   651,  7, 0,  4};
    vecs[11] = '{440,   430,  7, 0,  4};
    vecs[12] = '{440,     0,  0, 1,  4};
    vecs[13] = '{440,   460,  4, 0,  4};
    vecs[14] = '{440,   445, 10, 0,  4};

    rst = 1'b1; enable = 1'b1; start = 1'b0; clear_acc = 1'b0;
    sung_freq = '0; ref_freq = '0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    #1;
    check("reset busy",  int'(busy),  0);
    check("reset done",  int'(done),  0);
    check("reset score", int'(score), 0);
    check("reset oor",   int'(oor),   0);
    check("reset total", int'(total), 0);
    check("reset count", int'(count), 0);

    for (int i = 0; i < 15; i++) begin
      run_note(vecs[i].rf, vecs[i].sf, lat);
      model_add(vecs[i].exp_score);
      check($sformatf("vec%0d latency", i), lat, vecs[i].exp_lat);
      check($sformatf("vec%0d score", i), int'(score), vecs[i].exp_score);
      check($sformatf("vec%0d oor", i), int'(oor), vecs[i].exp_oor);
      check($sformatf("vec%0d total", i), int'(total), exp_total);
      check($sformatf("vec%0d count", i), int'(count), exp_count);
    end

    // Start while busy must be ignored.
    @(negedge clk);
    ref_freq = 15'd440; sung_freq = 15'd440; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    first = -1; ndone = 0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk);
      #1;
      if (c == 1) begin
        ref_freq = 15'd0; sung_freq = 15'd0; start = 1'b1;
      end
      if (c == 2) start = 1'b0;
      if (done) begin
        ndone++;
        if (first < 0) first = c;
      end
    end
    model_add(10);
    check("busy-start latency", first, 4);
    check("busy-start done count", ndone, 1);
    check("busy-start score", int'(score), 10);
    check("busy-start oor", int'(oor), 0);
    check("busy-start count", int'(count), exp_count);

    // clear_acc on its own.
    @(negedge clk) clear_acc = 1'b1;
    @(posedge clk);
    #1 clear_acc = 1'b0;
    exp_total = 0; exp_count = 0;
    check("clear total", int'(total), 0);
    check("clear count", int'(count), 0);

    // clear_acc coincident with DONE restarts totals from that note.
    run_note(440, 440, lat);
    model_add(10);
    check("pre-clear total", int'(total), 10);
    @(negedge clk);
    ref_freq = 15'd440; sung_freq = 15'd450; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #1 clear_acc = 1'b1;
    @(posedge clk);
    #1 clear_acc = 1'b0;
    exp_total = 7; exp_count = 1;
    check("clear+done pulse", int'(done), 1);
    check("clear+done score", int'(score), 7);
    check("clear+done total", int'(total), 7);
    check("clear+done count", int'(count), 1);

    // enable low for three cycles while in DIFF stretches latency by three.
    @(negedge clk);
    ref_freq = 15'd440; sung_freq = 15'd440; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    first = -1; ndone = 0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk);
      #1;
      if (c == 1) enable = 1'b0;
      if (c == 3) check("stall busy", int'(busy), 1);
      if (c == 4) enable = 1'b1;
      if (done) begin
        ndone++;
        if (first < 0) first = c;
      end
    end
    model_add(10);
    check("stall latency", first, 7);
    check("stall done count", ndone, 1);
    check("stall total", int'(total), exp_total);

    // Reset while in FOLD abandons the note.
    @(negedge clk);
    ref_freq = 15'd440; sung_freq = 15'd470; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    rst = 1'b1;
    #1;
    check("midreset busy",  int'(busy),  0);
    check("midreset done",  int'(done),  0);
    check("midreset score", int'(score), 0);
    check("midreset oor",   int'(oor),   0);
    check("midreset total", int'(total), 0);
    check("midreset count", int'(count), 0);
    @(negedge clk) rst = 1'b0;
    exp_total = 0; exp_count = 0;
    ndone = 0;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk);
      #1;
      if (done) ndone++;
    end
    check("midreset no done", ndone, 0);

    // Saturation, observed on the narrow-accumulator instance.
    for (int i = 0; i < 2; i++) begin
      run_note(440, 440, lat);
      model_add(10);
    end
    check("sat total after 2", int'(total2), 15);
    check("sat count after 2", int'(count2), 2);
    for (int i = 0; i < 15; i++) begin
      run_note(440, 440, lat);
      model_add(10);
    end
    check("sat total after 17", int'(total2), 15);
    check("sat count after 17", int'(count2), 15);
    check("wide total after 17", int'(total), exp_total);
    check("wide count after 17", int'(count), exp_count);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
